fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the architectural PC register.
- Issues single-outstanding requests to instruction memory and presents the fetched word to decode with a valid/ready handshake.
- Exports the current PC to the next-PC logic and loads that logic's new_pc result when decode accepts the instruction.
- Sits between the next-PC adder/branch logic and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and used for the first fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- new_pc  input  32  next PC from the next-PC logic; sampled only on the retire handshake.
- pc  output  32  PC of the instruction currently held or being fetched; feeds the next-PC logic.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc, with bits [1:0] forced to 0.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  imem_rdata is valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr_out holds a valid instruction.
- instr_ready  input  1  decode accepts instr_out this cycle.
- instr_out  output  32  fetched instruction held for decode.
- fetch_fault  output  1  misaligned-PC fault flag; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, instr_valid=0, instr_out=0, fetch_fault=0.
- States: IDLE, REQ, WAIT, VALID, FAULT. FAULT exists only with the macro.
- IDLE: imem_req=0; unconditional transition to REQ next cycle. This gives one bubble after reset release.
- REQ:
  - imem_req=1, imem_addr={pc[31:2],2'b00}.
  - Address and req stay stable until imem_gnt=1.
  - On gnt: go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid=1: instr_out<=imem_rdata, instr_valid<=1, go to VALID.
  - rvalid and gnt in the same REQ cycle is a protocol violation; rvalid is ignored in REQ.
- VALID:
  - instr_valid=1; instr_out and pc held stable while instr_ready=0.
  - Retire handshake = instr_valid && instr_ready: pc<=new_pc, instr_valid<=0, go to REQ.
- Latency:
  - gnt in cycle N, rvalid in cycle N+k (k>=1) -> instr_valid=1 in cycle N+k+1.
  - Retire in cycle M -> imem_req=1 with the new address in cycle M+1.
  - Peak throughput: one instruction per 3 cycles.
- Only one request is outstanding at a time. imem_rvalid is ignored outside WAIT; stray responses after a reset are dropped.
- pc is 32-bit with no saturation. new_pc=32'hFFFF_FFFC and 32'h0000_0000 load as-is; wrap handling belongs to the next-PC logic.
- instr_ready while instr_valid=0 has no effect.
- new_pc is don't-care except in the retire cycle.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined: on retire, if new_pc[1:0]!=0:
  - pc<=new_pc unmodified, go to FAULT.
  - FAULT: imem_req=0, instr_valid=0, fetch_fault=1.
  - FAULT is sticky until rst_n is asserted.
  - Aligned new_pc behaves normally.
- Undefined:
  - pc<={new_pc[31:2],2'b00} on retire.
  - fetch_fault tied 0; no FAULT state.

Test Plan:
1. Reset with RESET_PC=32'h0000_0100; hold imem_gnt=1, rvalid one cycle after gnt with rdata=32'h0000_0013, instr_ready=1 -> first imem_req=1 in the 2nd cycle after reset release with addr 0x100. instr_valid=1 with instr_out=0x13 two cycles after gnt.
2. imem_gnt held 0 for 5 cycles -> imem_req=1 and imem_addr=0x100 stable all 5 cycles. No state change until gnt.
3. instr_ready=0 for 4 cycles in VALID with new_pc toggling -> instr_out, pc, instr_valid stable. On ready=1 with new_pc=0x200, the next request addr=0x200.
4. Retire with new_pc=32'hFFFF_FFFC, then with new_pc=0x0 -> requests at 0xFFFF_FFFC, then 0x0, with no glitch.
5. Assert rst_n=0 in WAIT, release, then pulse a stray rvalid in IDLE/REQ -> response dropped, instr_valid stays 0, fetch restarts at RESET_PC.
6. With FETCH_MISALIGN_CHECK_EN, retire with new_pc=0x202 -> fetch_fault=1, imem_req=0 indefinitely, pc=0x202. Without the macro, the next fetch addr=0x200 and fetch_fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request, hands words to decode.
// Optional misaligned-PC fault trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] new_pc_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_out_o,
  output logic        fetch_fault_o
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StValid, StFault} state_e;
  logic fault_q;
`else
  typedef enum logic [2:0] {StIdle, StReq, StWait, StValid} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          // rvalid is deliberately ignored here; only one request is ever outstanding.
          if (imem_gnt_i) begin
            state_q <= StWait;
            req_q   <= 1'b0;
          end
        end
        StWait: begin
          if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            state_q <= StValid;
          end
        end
        StValid: begin
          if (instr_ready_i) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_q    <= new_pc_i;
            if (new_pc_i[1:0] != 2'b00) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              state_q <= StReq;
              req_q   <= 1'b1;
            end
`else
            pc_q    <= new_pc_i & 32'hFFFF_FFFC;
            state_q <= StReq;
            req_q   <= 1'b1;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        StFault: begin
          // Sticky until reset.
          state_q <= StFault;
        end
`endif
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign imem_req_o    = req_q;
  assign imem_addr_o   = {pc_q[31:2], 2'b00};
  assign instr_valid_o = valid_q;
  assign instr_out_o   = instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault_o = fault_q;
`else
  assign fetch_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus reset and misalignment sequences.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] new_pc_i;
  logic [31:0] pc_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_out_o;
  logic        fetch_fault_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .new_pc_i     (new_pc_i),
    .pc_o         (pc_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_out_o  (instr_out_o),
    .fetch_fault_o(fetch_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic rdy, input logic [31:0] npc, input logic e_req,
                              input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_instr);
    vec_t v;
    v.gnt = gnt; v.rvalid = rv; v.rdata = rdata; v.ready = rdy; v.npc = npc;
    v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_pc,
                         input logic e_valid, input logic [31:0] e_instr, input logic e_fault);
    chk({tag, ".req"},   {31'h0, imem_req_o},    {31'h0, e_req});
    chk({tag, ".pc"},    pc_o,                   e_pc);
    chk({tag, ".addr"},  imem_addr_o,            e_pc & 32'hFFFF_FFFC);
    chk({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, e_valid});
    chk({tag, ".instr"}, instr_out_o,            e_instr);
    chk({tag, ".fault"}, {31'h0, fetch_fault_o}, {31'h0, e_fault});
  endtask

  task automatic step(input logic gnt, input logic rv, input logic [31:0] rdata,
                      input logic rdy, input logic [31:0] npc);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rdata;
    instr_ready_i = rdy;
    new_pc_i      = npc;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset-release bubble, stalled grant with stray rvalid, then normal fetches.
    add(0, 0, 32'h0,         1, 32'h0,         1, ResetPc,      0, 32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'hBAD0,    0, 32'h0,         1, ResetPc,      0, 32'h0);
    add(1, 1, 32'hBAD1,      1, 32'h0,         0, ResetPc,      0, 32'h0);
    add(0, 0, 32'h0,         1, 32'h999,       0, ResetPc,      0, 32'h0);
    add(0, 1, 32'h13,        0, 32'h0,         0, ResetPc,      1, 32'h13);
    for (int i = 0; i < 4; i++)
      add(0, 0, 32'h0,       0, (i % 2 == 0) ? 32'h300 : 32'h404, 0, ResetPc, 1, 32'h13);
    add(0, 0, 32'h0,         1, 32'h200,       1, 32'h200,      0, 32'h13);
    add(1, 0, 32'h0,         0, 32'h0,         0, 32'h200,      0, 32'h13);
    add(0, 1, 32'hAABBCCDD,  0, 32'h0,         0, 32'h200,      1, 32'hAABBCCDD);
    add(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'hAABBCCDD);
    add(1, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'hAABBCCDD);
    add(0, 1, 32'h11,        0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h11);
    add(0, 0, 32'h0,         1, 32'h0,         1, 32'h0,        0, 32'h11);
    add(1, 0, 32'h0,         0, 32'h0,         0, 32'h0,        0, 32'h11);
    add(0, 1, 32'h22,        0, 32'h0,         0, 32'h0,        1, 32'h22);

    rst_ni = 1'b0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    instr_ready_i = 1'b1; new_pc_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("reset", 0, ResetPc, 0, 32'h0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, vecs[i].npc);
      chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_valid,
              vecs[i].e_instr, 0);
    end

    // Misaligned retire target.
    step(0, 0, 32'h0, 1, 32'h202);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk_all("mis", 0, 32'h202, 0, 32'h22, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'h77, 1, 32'h400);
      chk_all($sformatf("mis_sticky%0d", i), 0, 32'h202, 0, 32'h22, 1);
    end
`else
    chk_all("mis", 1, 32'h200, 0, 32'h22, 0);
    step(1, 0, 32'h0, 0, 32'h0);
    chk_all("mis_wait", 0, 32'h200, 0, 32'h22, 0);
`endif

    // Asynchronous reset mid-cycle, then stray responses must be dropped.
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all("async_rst", 0, ResetPc, 0, 32'h0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 1, 32'hDEAD, 1, 32'h0);
    chk_all("stray0", 1, ResetPc, 0, 32'h0, 0);
    step(0, 1, 32'hBEEF, 1, 32'h0);
    chk_all("stray1", 1, ResetPc, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1, 32'h0);
    chk_all("rst_gnt", 0, ResetPc, 0, 32'h0, 0);
    step(0, 1, 32'h55, 0, 32'h0);
    chk_all("rst_rv", 0, ResetPc, 1, 32'h55, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
